sdu_mem_reader: RTL
===================

Name: sdu_mem_reader

Overview:
- Debug-side reader for the data memory's second, asynchronous read port (dpra/dpo).
- On a start command it walks a word-address window of the data memory and streams each word out over a valid/ready interface, tagged with its word address.
- It accumulates a 32-bit additive checksum of the streamed words.
- It sits between the data memory debug read port and the step/debug unit (or a UART dumper), so memory can be dumped without touching the CPU-side path.

Parameters:
- AW, 10, word-address width of data memory (depth 2^AW words)
- DW, 32, data word width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle command pulse; sampled only in IDLE
- abort  in  1  cancel the dump in progress; sampled in every state
- base_addr  in  AW  first word address of the window
- word_count  in  AW+1  number of words to read; 0..2^AW
- sdu_raddr  out  32  read address to the data memory debug port, {zeros, ptr}
- sdu_rdata  in  DW  combinational read data from the debug port, same cycle
- out_valid  out  1  out_data/out_addr hold a word
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- out_data  out  DW  streamed word
- out_addr  out  AW  word address of out_data
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on normal completion
- checksum  out  32  wraparound sum of words accepted since last start; held after done

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, ptr=0, remaining=0
  - out_valid=0, out_data=0, out_addr=0
  - busy=0, done=0, checksum=0
  - Reset wins over start and abort in the same cycle.
- States: IDLE, RUN.
- sdu_raddr is combinational {(32-AW)'b0, ptr} in all states.
- done defaults to 0 every cycle.
- IDLE:
  - start=1, word_count!=0: ptr<=base_addr, remaining<=word_count, checksum<=0, go RUN.
  - start=1, word_count==0: checksum<=0, done<=1, stay IDLE, no words emitted.
- RUN, evaluated each edge with slot_free = !out_valid || out_ready:
  - Handshake accounting: if out_valid && out_ready, checksum<=checksum+out_data, modulo 2^32.
  - Load path: slot_free && remaining!=0: out_data<=sdu_rdata, out_addr<=ptr, out_valid<=1, ptr<=ptr+1 (wraps mod 2^AW, 1023 -> 0), remaining<=remaining-1.
  - Drain path: slot_free && remaining==0: out_valid<=0, done<=1, go IDLE. The final handshake's checksum update happens at this same edge.
  - Stall: !slot_free: hold everything. out_data and out_addr must stay stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - start sampled at edge k -> first out_valid=1 after edge k+1.
  - With out_ready held high, one word per cycle.
  - done follows edge N+1 after k, then IDLE.
- abort=1 in RUN (rst=0): go IDLE, out_valid<=0, remaining<=0, no done pulse. checksum keeps its partial value, including a handshake occurring that same cycle.
- start while busy: ignored.
- busy = (state==RUN).
- word_count=2^AW: reads the whole memory exactly once, wrapping if base_addr!=0.
- out_ready while out_valid=0: ignored.

Decomposition:
- Package sdu_mem_reader_pkg:
  - state encoding (IDLE=1'b0, RUN=1'b1)
  - default AW/DW constants shared with the data memory (DM_AW=10, DM_DW=32)
- No sub-module needed.
- The output holding stage (valid/data/addr) could be factored as sdu_out_slot, but it is inline by default.

Test Plan:
- Preload mem[0x10..0x13]={1,2,3,0xFFFFFFFF}; start base=0x10 count=4, ready=1 -> out_addr 0x10..0x13 on four consecutive cycles, first valid one cycle after start; done one cycle after last word; checksum=0x00000005.
- Same window, ready toggled 1,0,0,1,0,1,1 -> no word lost or duplicated; data/addr stable during stalls; busy=1 until done; checksum=5.
- Preload mem[0x3FE]=A, mem[0x3FF]=B, mem[0]=C; start base=0x3FE count=3 -> out_addr 0x3FE, 0x3FF, 0x000; data A, B, C.
- start with count=0 -> done pulses next cycle; out_valid never asserts; checksum=0. start pulsed while busy -> ignored, original dump completes unchanged.
- Abort after second accepted word of an 8-word dump -> out_valid=0 and busy=0 next cycle; no done; checksum=sum of two words. A subsequent start then works normally.
- rst=1 mid-dump concurrent with start and out_ready=1 -> all outputs return to reset values the next cycle; sdu_raddr=0.

Source files
------------

// File: rtl/sdu_mem_reader_pkg.sv
// Purpose: shared types and constants for the debug memory reader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sdu_mem_reader_pkg;

    // Geometry of the data memory this reader is attached to.
    localparam int DM_AW = 10;
    localparam int DM_DW = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sdu_mem_reader.sv
// Purpose: walks a word-address window of the data memory debug port and streams
//          {addr, data} over valid/ready, keeping a 32-bit additive checksum.
// Latency: start sampled at edge k -> first word valid after edge k+1; 1 word/cycle.
// Backpressure: single output slot; data/addr held stable while valid && !ready.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_abort    command pulse (IDLE only) / cancel (any state)
//   i_base_addr         first word address of the window
//   i_word_count        number of words, 0..2^AW
//   o_sdu_raddr         debug read address {zeros, ptr}
//   i_sdu_rdata         combinational read data for o_sdu_raddr
//   o_out_valid/i_out_ready/o_out_data/o_out_addr   output stream
//   o_busy, o_done      running flag / completion pulse
//   o_checksum          sum of accepted words since last start
module sdu_mem_reader
    import sdu_mem_reader_pkg::*;
#(
    parameter int AW = DM_AW,
    parameter int DW = DM_DW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [AW-1:0] i_base_addr,
    input  logic [AW:0]   i_word_count,
    output logic [31:0]   o_sdu_raddr,
    input  logic [DW-1:0] i_sdu_rdata,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_data,
    output logic [AW-1:0] o_out_addr,
    output logic          o_busy,
    output logic          o_done,
    output logic [31:0]   o_checksum
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   REM_ONE = (AW + 1)'(1);

    state_t        r_state,     w_state_nxt;
    logic [AW-1:0] r_ptr,       w_ptr_nxt;
    logic [AW:0]   r_remaining, w_remaining_nxt;
    logic          r_out_valid, w_out_valid_nxt;
    logic [DW-1:0] r_out_data,  w_out_data_nxt;
    logic [AW-1:0] r_out_addr,  w_out_addr_nxt;
    logic          r_done,      w_done_nxt;
    logic [31:0]   r_checksum,  w_checksum_nxt;

    logic          w_handshake;
    logic          w_slot_free;

    assign w_handshake = r_out_valid && i_out_ready;
    // The slot can take a new word when empty or when its current word leaves this cycle.
    assign w_slot_free = !r_out_valid || i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_done      <= 1'b0;
            r_checksum  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_remaining <= w_remaining_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_addr  <= w_out_addr_nxt;
            r_done      <= w_done_nxt;
            r_checksum  <= w_checksum_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_remaining_nxt = r_remaining;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_addr_nxt  = r_out_addr;
        w_done_nxt      = 1'b0;
        w_checksum_nxt  = r_checksum;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_checksum_nxt = '0;
                    if (i_word_count != '0) begin
                        w_ptr_nxt       = i_base_addr;
                        w_remaining_nxt = i_word_count;
                        w_state_nxt     = ST_RUN;
                    end else begin
                        // Empty window: complete immediately without emitting anything.
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // A word accepted this cycle is counted even if the dump is aborted now.
                if (w_handshake) begin
                    w_checksum_nxt = r_checksum + 32'(r_out_data);
                end
                if (i_abort) begin
                    w_state_nxt     = ST_IDLE;
                    w_out_valid_nxt = 1'b0;
                    w_remaining_nxt = '0;
                end else if (w_slot_free) begin
                    if (r_remaining != '0) begin
                        w_out_data_nxt  = i_sdu_rdata;
                        w_out_addr_nxt  = r_ptr;
                        w_out_valid_nxt = 1'b1;
                        w_ptr_nxt       = r_ptr + PTR_ONE;
                        w_remaining_nxt = r_remaining - REM_ONE;
                    end else begin
                        // Last word has left the slot: finish.
                        w_out_valid_nxt = 1'b0;
                        w_done_nxt      = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_sdu_raddr = {{(32 - AW){1'b0}}, r_ptr};
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_addr  = r_out_addr;
    assign o_busy      = (r_state == ST_RUN);
    assign o_done      = r_done;
    assign o_checksum  = r_checksum;

endmodule
